// File: rtl/nco_ctrl_pkg.sv
// Shared types and default widths for the NCO sweep controller.
package nco_ctrl_pkg;

    localparam int ACC_W_DEF   = 16;
    localparam int DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        FIXED      = 2'd0,
        SWEEP_ONCE = 2'd1,
        SWEEP_LOOP = 2'd2,
        STOP       = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        HOLD  = 2'd2
    } state_e;

endpackage

// File: rtl/nco_rate_acc.sv
// Fractional rate accumulator: emits a one-cycle registered strobe on every carry out.
module nco_rate_acc #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [ACC_W-1:0] rate,
    output logic             next
);

    logic [ACC_W-1:0] r_acc;
    logic             r_next;
    logic [ACC_W:0]   w_sum;

    assign w_sum = {1'b0, r_acc} + {1'b0, rate};

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_acc  <= '0;
            r_next <= 1'b0;
        end else if (en) begin
            r_acc  <= w_sum[ACC_W-1:0];
            r_next <= w_sum[ACC_W];
        end else begin
            r_next <= 1'b0;
        end
    end

    assign next = r_next;

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Sweep controller: config handshake, dwell timing and rate stepping ahead of the NCO strobe.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [1:0]         cfg_mode,
    input  logic [ACC_W-1:0]   cfg_start_rate,
    input  logic [ACC_W-1:0]   cfg_stop_rate,
    input  logic [ACC_W-1:0]   cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               enable,
    output logic               next,
    output logic [ACC_W-1:0]   rate,
    output logic               busy,
    output logic               done
);

    state_e             r_state;
    mode_e              r_mode;
    logic [ACC_W-1:0]   r_rate;
    logic [ACC_W-1:0]   r_start;
    logic [ACC_W-1:0]   r_stop;
    logic [ACC_W-1:0]   r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               r_done;

    logic               w_accept;
    logic               w_run;
    logic [ACC_W:0]     w_sum;

    assign cfg_ready = (r_state != SWEEP);
    assign busy      = (r_state == SWEEP);
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_run     = enable && (r_state != IDLE);
    // One extra bit so a step past the top of the rate range still compares against stop.
    assign w_sum     = {1'b0, r_rate} + {1'b0, r_step};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= FIXED;
            r_rate      <= '0;
            r_start     <= '0;
            r_stop      <= '0;
            r_step      <= '0;
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_mode      <= mode_e'(cfg_mode);
                r_start     <= cfg_start_rate;
                r_stop      <= cfg_stop_rate;
                r_step      <= cfg_step;
                r_dwell     <= cfg_dwell;
                r_dwell_cnt <= '0;
                case (mode_e'(cfg_mode))
                    FIXED: begin
                        r_rate  <= cfg_start_rate;
                        r_state <= HOLD;
                    end
                    SWEEP_ONCE, SWEEP_LOOP: begin
                        r_rate  <= cfg_start_rate;
                        r_state <= SWEEP;
                    end
                    default: begin
                        r_rate  <= '0;
                        r_state <= IDLE;
                    end
                endcase
            end else if (enable && r_state == SWEEP) begin
                if (r_dwell_cnt == r_dwell) begin
                    r_dwell_cnt <= '0;
                    if (w_sum >= {1'b0, r_stop}) begin
                        r_done <= 1'b1;
                        if (r_mode == SWEEP_LOOP) begin
                            r_rate <= r_start;
                        end else begin
                            r_rate  <= r_stop;
                            r_state <= HOLD;
                        end
                    end else begin
                        r_rate <= w_sum[ACC_W-1:0];
                    end
                end else begin
                    r_dwell_cnt <= r_dwell_cnt + DWELL_W'(1);
                end
            end
        end
    end

    assign rate = r_rate;
    assign done = r_done;

    nco_rate_acc #(
        .ACC_W (ACC_W)
    ) u_rate_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_accept),
        .en   (w_run),
        .rate (r_rate),
        .next (next)
    );

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Randomised and directed bench for nco_sweep_ctrl against a segment/phase-sum reference model.
module tb_nco_sweep_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MAXN = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_mode;
    logic [AW-1:0] cfg_start_rate;
    logic [AW-1:0] cfg_stop_rate;
    logic [AW-1:0] cfg_step;
    logic [DW-1:0] cfg_dwell;
    logic          enable;
    logic          next;
    logic [AW-1:0] rate;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs indexed by the number of enabled edges since the accept edge.
    int m_rate [MAXN];
    bit m_next [MAXN];
    bit m_done [MAXN];
    bit m_busy [MAXN];

    always #5 clk = ~clk;

    nco_sweep_ctrl #(.ACC_W(AW), .DWELL_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_mode       (cfg_mode),
        .cfg_start_rate (cfg_start_rate),
        .cfg_stop_rate  (cfg_stop_rate),
        .cfg_step       (cfg_step),
        .cfg_dwell      (cfg_dwell),
        .enable         (enable),
        .next           (next),
        .rate           (rate),
        .busy           (busy),
        .done           (done)
    );

    // Rate schedule as a list of dwell segments; strobes come from the running phase sum crossing 2^AW.
    task automatic build_model(input int mode, input int start, input int stop,
                               input int step, input int dwell, input int n);
        int  r;
        bit  sweeping;
        bit  d;
        int  sum;
        longint phase;
        longint prev;
        r        = (mode == 3) ? 0 : start;
        sweeping = (mode == 1 || mode == 2);
        d        = 1'b0;
        for (int i = 0; i < n && i < MAXN; i++) begin
            m_rate[i] = r;
            m_busy[i] = sweeping;
            m_done[i] = d;
            d = 1'b0;
            if (sweeping && ((i + 1) % (dwell + 1)) == 0) begin
                sum = r + step;
                if (sum >= stop) begin
                    d = 1'b1;
                    if (mode == 2) r = start;
                    else begin
                        r = stop;
                        sweeping = 1'b0;
                    end
                end else begin
                    r = sum;
                end
            end
        end
        phase     = 0;
        m_next[0] = 1'b0;
        for (int i = 1; i < n && i < MAXN; i++) begin
            prev      = phase;
            phase     = phase + m_rate[i-1];
            m_next[i] = (phase / (1 << AW)) != (prev / (1 << AW));
        end
    endtask

    task automatic apply_reset(input int cycles);
        rst       = 1'b1;
        cfg_valid = 1'b0;
        enable    = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_accept(input int mode, input int start, input int stop,
                             input int step, input int dwell, input int n);
        int exp_rate;
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready: cfg_ready=%b expected 1", cfg_ready);
        end
        cfg_mode       = 2'(mode);
        cfg_start_rate = AW'(start);
        cfg_stop_rate  = AW'(stop);
        cfg_step       = AW'(step);
        cfg_dwell      = DW'(dwell);
        cfg_valid      = 1'b1;
        enable         = 1'b1;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        exp_rate  = (mode == 3) ? 0 : start;
        n_checks++;
        if (rate !== AW'(exp_rate) || next !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_load: rate=%0d next=%b done=%b expected rate=%0d next=0 done=0",
                     rate, next, done, exp_rate);
        end
        build_model(mode, start, stop, step, dwell, n);
    endtask

    // Runs `edges` clocks after an accept, pausing on real edges pause_at+1..pause_at+len.
    task automatic run_against_model(input string tag, input int edges, input int pause_at,
                                     input int pause_len, input bit hold_valid,
                                     output int done_edge, output int done_cnt,
                                     output int pulses, output int first_next, output int max_rate);
        int idx;
        bit en;
        bit e_next;
        bit e_done;
        bit e_busy;
        int e_rate;
        idx        = 0;
        done_edge  = -1;
        done_cnt   = 0;
        pulses     = 0;
        first_next = -1;
        max_rate   = 0;
        for (int e = 1; e <= edges; e++) begin
            en        = !(e > pause_at && e <= pause_at + pause_len);
            enable    = en;
            cfg_valid = hold_valid;
            if (hold_valid) begin
                cfg_mode       = 2'd0;
                cfg_start_rate = 8'd200;
            end
            @(posedge clk);
            #1;
            if (en) idx++;
            e_rate = m_rate[idx];
            e_busy = m_busy[idx];
            e_next = en ? m_next[idx] : 1'b0;
            e_done = en ? m_done[idx] : 1'b0;
            n_checks++;
            if (rate !== AW'(e_rate) || next !== e_next || done !== e_done ||
                busy !== e_busy || cfg_ready !== !e_busy) begin
                n_fail++;
                $display("FAIL %s edge %0d: rate=%0d next=%b done=%b busy=%b ready=%b expected rate=%0d next=%b done=%b busy=%b ready=%b",
                         tag, e, rate, next, done, busy, cfg_ready,
                         e_rate, e_next, e_done, e_busy, !e_busy);
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
            if (next === 1'b1) begin
                pulses++;
                if (first_next < 0) first_next = e;
            end
            if (int'(rate) > max_rate) max_rate = int'(rate);
        end
        enable    = 1'b1;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cfg_valid = 1'b0;
        enable    = 1'b1;
        cfg_mode  = '0; cfg_start_rate = '0; cfg_stop_rate = '0; cfg_step = '0; cfg_dwell = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (next !== 1'b0 || rate !== '0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_hold: next=%b rate=%0d busy=%b done=%b ready=%b expected 0 0 0 0 1",
                         next, rate, busy, done, cfg_ready);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (next !== 1'b0 || rate !== '0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: next=%b rate=%0d busy=%b done=%b ready=%b expected 0 0 0 0 1",
                         i, next, rate, busy, done, cfg_ready);
            end
        end
    endtask

    task automatic test_fixed();
        int de, dc, pl, fn, mr;
        apply_reset(1);
        do_accept(0, 64, 0, 0, 0, 401);
        run_against_model("fixed", 400, 1000, 0, 1'b0, de, dc, pl, fn, mr);
        n_checks++;
        if (fn !== 4 || pl !== 100 || dc !== 0) begin
            n_fail++;
            $display("FAIL fixed_count: first=%0d pulses=%0d dones=%0d expected first=4 pulses=100 dones=0",
                     fn, pl, dc);
        end
    endtask

    task automatic test_sweep_once();
        int de, dc, pl, fn, mr;
        apply_reset(1);
        do_accept(1, 16, 64, 16, 9, 101);
        run_against_model("sweep_once", 100, 1000, 0, 1'b0, de, dc, pl, fn, mr);
        n_checks++;
        if (de !== 30 || dc !== 1 || rate !== 8'd64 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep_once_end: done_edge=%0d dones=%0d rate=%0d busy=%b ready=%b expected 30 1 64 0 1",
                     de, dc, rate, busy, cfg_ready);
        end
    endtask

    task automatic test_sweep_loop();
        int de, dc, pl, fn, mr;
        apply_reset(1);
        do_accept(2, 16, 64, 16, 9, 101);
        run_against_model("sweep_loop", 100, 1000, 0, 1'b1, de, dc, pl, fn, mr);
        n_checks++;
        if (de !== 30 || dc !== 3 || mr !== 48) begin
            n_fail++;
            $display("FAIL sweep_loop_wrap: done_edge=%0d dones=%0d max_rate=%0d expected 30 3 48",
                     de, dc, mr);
        end
    endtask

    task automatic test_pause();
        int de, dc, pl, fn, mr;
        apply_reset(1);
        do_accept(1, 16, 64, 16, 9, 101);
        run_against_model("pause", 100, 15, 5, 1'b0, de, dc, pl, fn, mr);
        n_checks++;
        if (de !== 35 || dc !== 1) begin
            n_fail++;
            $display("FAIL pause_done: done_edge=%0d dones=%0d expected 35 1", de, dc);
        end
    endtask

    task automatic test_reset_mid_and_stop();
        int de, dc, pl, fn, mr;
        apply_reset(1);
        do_accept(1, 16, 64, 16, 9, 101);
        run_against_model("pre_reset", 14, 1000, 0, 1'b0, de, dc, pl, fn, mr);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (next !== 1'b0 || rate !== '0 || busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid: next=%b rate=%0d busy=%b done=%b ready=%b expected 0 0 0 0 1",
                     next, rate, busy, done, cfg_ready);
        end
        build_model(3, 0, 0, 0, 0, 41);
        run_against_model("post_reset", 40, 1000, 0, 1'b0, de, dc, pl, fn, mr);
        do_accept(1, 16, 64, 16, 9, 41);
        run_against_model("to_hold", 40, 1000, 0, 1'b0, de, dc, pl, fn, mr);
        do_accept(3, 99, 0, 0, 0, 31);
        run_against_model("stop", 30, 1000, 0, 1'b0, de, dc, pl, fn, mr);
        n_checks++;
        if (pl !== 0 || rate !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stop_idle: pulses=%0d rate=%0d busy=%b expected 0 0 0", pl, rate, busy);
        end
    endtask

    task automatic test_random();
        int de, dc, pl, fn, mr;
        int mode, start, stop, step, dwell, pat, plen;
        for (int it = 0; it < 10; it++) begin
            mode  = $urandom_range(0, 2);
            start = $urandom_range(0, 255);
            stop  = $urandom_range(0, 255);
            step  = $urandom_range(0, 80);
            dwell = $urandom_range(0, 12);
            pat   = $urandom_range(0, 100);
            plen  = $urandom_range(0, 8);
            apply_reset(1);
            do_accept(mode, start, stop, step, dwell, 151);
            run_against_model("random", 150, pat, plen, 1'b0, de, dc, pl, fn, mr);
        end
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_sweep_once();
        test_sweep_loop();
        test_pause();
        test_reset_mid_and_stop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
